// File: rtl/y86_alu_if.sv
// rtl/y86_alu_if.sv - operand/result bundle between the execute stage and the ALU
interface y86_alu_if;
  logic [1:0]         control;
  logic signed [63:0] a;
  logic signed [63:0] b;
  logic signed [63:0] ans;
  logic               overflow;

  modport master (
    output control,
    output a,
    output b,
    input  ans,
    input  overflow
  );

  modport slave (
    input  control,
    input  a,
    input  b,
    output ans,
    output overflow
  );
endinterface

// File: rtl/y86_alu.sv
// rtl/y86_alu.sv - 64-bit Y86 ALU: ripple add/sub, and, xor, signed overflow, registered
module y86_full_adder (
  input  logic x,
  input  logic y,
  input  logic cin,
  output logic sum,
  output logic cout
);
  assign sum  = x ^ y ^ cin;
  assign cout = (x & y) | (cin & (x ^ y));
endmodule

module y86_alu (
  input  logic       clk,
  input  logic       rst_n,
  y86_alu_if.slave   bus
);
  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;
  localparam logic [1:0] OP_XOR = 2'b11;

  logic        sub_sel;
  logic [63:0] b_in;
  logic [64:0] carry;
  logic [63:0] sum;
  logic        unused_carry_out;

  logic [63:0] ans_d, ans_q;
  logic        ov_d, ov_q;

  // Subtraction reuses the adder: invert B and inject a carry-in of one.
  assign sub_sel  = (bus.control == OP_SUB);
  assign b_in     = bus.b ^ {64{sub_sel}};
  assign carry[0] = sub_sel;

  genvar i;
  generate
    for (i = 0; i < 64; i++) begin : g_ripple
      y86_full_adder u_fa (
        .x    (bus.a[i]),
        .y    (b_in[i]),
        .cin  (carry[i]),
        .sum  (sum[i]),
        .cout (carry[i+1])
      );
    end
  endgenerate

  // Unsigned carry-out is kept for observability only; overflow uses sign bits.
  assign unused_carry_out = carry[64];

  // Result mux and signed-overflow detection, logic ops in parallel with the adder.
  always_comb begin
    ans_d = '0;
    ov_d  = 1'b0;
    case (bus.control)
      OP_ADD: begin
        ans_d = sum;
        ov_d  = (bus.a[63] == bus.b[63]) && (sum[63] != bus.a[63]);
      end
      OP_SUB: begin
        ans_d = sum;
        ov_d  = (bus.a[63] != bus.b[63]) && (sum[63] != bus.a[63]);
      end
      OP_AND:  ans_d = bus.a & bus.b;
      OP_XOR:  ans_d = bus.a ^ bus.b;
      default: ans_d = '0;
    endcase
  end

  // Output register; reset clears any captured result immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ans_q <= '0;
      ov_q  <= 1'b0;
    end else begin
      ans_q <= ans_d;
      ov_q  <= ov_d;
    end
  end

  assign bus.ans      = ans_q;
  assign bus.overflow = ov_q;
endmodule

// File: tb/tb_y86_alu.sv
// tb/tb_y86_alu.sv - directed self-checking bench for y86_alu
module tb_y86_alu;
  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  localparam logic signed [63:0] MAX = 64'sh7FFF_FFFF_FFFF_FFFF;
  localparam logic signed [63:0] MIN = 64'sh8000_0000_0000_0000;

  y86_alu_if bus ();

  y86_alu dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic signed [63:0] exp_ans, input logic exp_ov);
    checks++;
    assert (bus.ans === exp_ans) else begin
      errors++;
      $error("FAIL %s ans observed %0d expected %0d", tag, bus.ans, exp_ans);
    end
    checks++;
    assert (bus.overflow === exp_ov) else begin
      errors++;
      $error("FAIL %s overflow observed %0b expected %0b", tag, bus.overflow, exp_ov);
    end
  endtask

  task automatic drive(input logic [1:0] ctrl, input logic signed [63:0] av, input logic signed [63:0] bv);
    bus.control = ctrl;
    bus.a       = av;
    bus.b       = bv;
  endtask

  task automatic op(input string tag, input logic [1:0] ctrl, input logic signed [63:0] av,
                    input logic signed [63:0] bv, input logic signed [63:0] exp_ans, input logic exp_ov);
    drive(ctrl, av, bv);
    @(posedge clk);
    #1;
    check(tag, exp_ans, exp_ov);
  endtask

  logic [1:0]         bb_ctrl [8];
  logic signed [63:0] bb_a    [8];
  logic signed [63:0] bb_b    [8];
  logic signed [63:0] bb_exp  [8];
  logic               bb_ov   [8];

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    drive(2'b00, 64'sd11, 64'sd4);
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", 64'sd0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    op("add_11_4", 2'b00, 64'sd11, 64'sd4, 64'sd15, 1'b0);
    op("sub_11_4", 2'b01, 64'sd11, 64'sd4, 64'sd7,  1'b0);
    op("and_11_4", 2'b10, 64'sd11, 64'sd4, 64'sd0,  1'b0);
    op("xor_11_4", 2'b11, 64'sd11, 64'sd4, 64'sd15, 1'b0);

    op("add_m11_4", 2'b00, -64'sd11, 64'sd4, -64'sd7,  1'b0);
    op("sub_m11_4", 2'b01, -64'sd11, 64'sd4, -64'sd15, 1'b0);
    op("and_m11_4", 2'b10, -64'sd11, 64'sd4, 64'sd4,   1'b0);
    op("xor_m11_4", 2'b11, -64'sd11, 64'sd4, -64'sd15, 1'b0);

    op("add_11_m4", 2'b00, 64'sd11, -64'sd4, 64'sd7,  1'b0);
    op("sub_11_m4", 2'b01, 64'sd11, -64'sd4, 64'sd15, 1'b0);
    op("and_11_m4", 2'b10, 64'sd11, -64'sd4, 64'sd8,  1'b0);
    op("xor_11_m4", 2'b11, 64'sd11, -64'sd4, -64'sd9, 1'b0);

    op("add_m11_m4", 2'b00, -64'sd11, -64'sd4, -64'sd15, 1'b0);
    op("sub_m11_m4", 2'b01, -64'sd11, -64'sd4, -64'sd7,  1'b0);
    op("and_m11_m4", 2'b10, -64'sd11, -64'sd4, -64'sd12, 1'b0);
    op("xor_m11_m4", 2'b11, -64'sd11, -64'sd4, 64'sd9,   1'b0);

    op("add_2g_1",    2'b00, 64'sd2147483647, 64'sd1, 64'sd2147483648, 1'b0);
    op("sub_max_min", 2'b01, MAX, MIN, -64'sd1, 1'b1);
    op("sub_min_max", 2'b01, MIN, MAX, 64'sd1,  1'b1);
    op("sub_max_max", 2'b01, MAX, MAX, 64'sd0,  1'b0);
    op("sub_min_min", 2'b01, MIN, MIN, 64'sd0,  1'b0);
    op("add_max_1",   2'b00, MAX, 64'sd1, MIN,  1'b1);
    op("add_min_min", 2'b00, MIN, MIN, 64'sd0,  1'b1);
    op("sub_5_14",    2'b01, 64'sd5, 64'sd14, -64'sd9, 1'b0);

    // Inputs changed between edges must not disturb the registered outputs.
    op("hold_base", 2'b00, 64'sd11, 64'sd4, 64'sd15, 1'b0);
    drive(2'b01, MAX, MIN);
    #2;
    check("hold_midcycle", 64'sd15, 1'b0);

    // Asynchronous reset while a non-zero, overflowing result is held.
    op("pre_reset", 2'b00, MAX, 64'sd1, MIN, 1'b1);
    #1;
    rst_n = 1'b0;
    #1;
    check("async_reset", 64'sd0, 1'b0);
    drive(2'b00, 64'sd3, 64'sd2);
    @(posedge clk);
    #1;
    check("reset_held", 64'sd0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("after_release", 64'sd5, 1'b0);

    // Back-to-back: a new operation every cycle, each result one cycle later.
    bb_ctrl[0] = 2'b00; bb_a[0] = 64'sd100;  bb_b[0] = 64'sd23;  bb_exp[0] = 64'sd123;  bb_ov[0] = 1'b0;
    bb_ctrl[1] = 2'b01; bb_a[1] = 64'sd100;  bb_b[1] = 64'sd23;  bb_exp[1] = 64'sd77;   bb_ov[1] = 1'b0;
    bb_ctrl[2] = 2'b10; bb_a[2] = 64'sd12;   bb_b[2] = 64'sd10;  bb_exp[2] = 64'sd8;    bb_ov[2] = 1'b0;
    bb_ctrl[3] = 2'b11; bb_a[3] = 64'sd12;   bb_b[3] = 64'sd10;  bb_exp[3] = 64'sd6;    bb_ov[3] = 1'b0;
    bb_ctrl[4] = 2'b00; bb_a[4] = MAX;       bb_b[4] = MAX;      bb_exp[4] = -64'sd2;   bb_ov[4] = 1'b1;
    bb_ctrl[5] = 2'b01; bb_a[5] = 64'sd0;    bb_b[5] = 64'sd1;   bb_exp[5] = -64'sd1;   bb_ov[5] = 1'b0;
    bb_ctrl[6] = 2'b01; bb_a[6] = MIN;       bb_b[6] = 64'sd1;   bb_exp[6] = MAX;       bb_ov[6] = 1'b1;
    bb_ctrl[7] = 2'b00; bb_a[7] = -64'sd50;  bb_b[7] = 64'sd8;   bb_exp[7] = -64'sd42;  bb_ov[7] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      op($sformatf("b2b_%0d", i), bb_ctrl[i], bb_a[i], bb_b[i], bb_exp[i], bb_ov[i]);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
